// File: rtl/spi_flash_xip_slave.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module      : spi_flash_xip_slave
// Description : System-clocked SPI flash responder (mode 0). Oversamples the
//               SPI pins with `clock`, decodes a {cmd 8b, addr 24b} read
//               header and streams flash bytes MSB-first from a word-wide
//               memory port. Only READ_CMD is serviced; any other command
//               byte parks the frame in IGNORE until chip select rises.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock      in   1   system clock; all SPI pins sampled on its rising edge
//   reset      in   1   asynchronous, active-high
//   spi_sck    in   1   SPI clock from master, idle low
//   spi_ss_n   in   1   chip select, active low
//   spi_mosi   in   1   master-out data, sampled on SCK rise
//   spi_miso   out  1   slave-out data, updated one cycle after SCK fall
//   mem_req    out  1   one-cycle read strobe to the flash image memory
//   mem_addr   out  22  word address (flash byte address [23:2])
//   mem_rdata  in   32  read data, valid the cycle after mem_req
//   busy       out  1   high whenever the frame state machine is not idle
// Parameters
//   SYNC_STAGES  flops per pin synchronizer (>= 2)
//   READ_CMD     the only command byte that starts a read stream
// ============================================================================
module spi_flash_xip_slave #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] READ_CMD    = 8'h03
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        spi_sck,
    input  logic        spi_ss_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        mem_req,
    output logic [21:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int c_sync_msb = SYNC_STAGES - 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_FETCH  = 3'd3,
        ST_DATA   = 3'd4,
        ST_IGNORE = 3'd5
    } state_t;

    // ------------------------------------------------------------------------
    // Pin synchronizers and edge detection
    // ------------------------------------------------------------------------
    logic [c_sync_msb:0] r_sck_sync;
    logic [c_sync_msb:0] r_ss_sync;
    logic [c_sync_msb:0] r_mosi_sync;
    logic                r_sck_prev;
    logic                r_ss_prev;

    // The chip-select chain resets to its idle (deasserted) level so that
    // leaving reset never looks like a select edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sck_sync  <= '0;
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_sck_prev  <= 1'b0;
            r_ss_prev   <= 1'b1;
        end else begin
            r_sck_sync  <= {r_sck_sync[c_sync_msb-1:0], spi_sck};
            r_ss_sync   <= {r_ss_sync[c_sync_msb-1:0], spi_ss_n};
            r_mosi_sync <= {r_mosi_sync[c_sync_msb-1:0], spi_mosi};
            r_sck_prev  <= r_sck_sync[c_sync_msb];
            r_ss_prev   <= r_ss_sync[c_sync_msb];
        end
    end

    logic w_sck;
    logic w_ss_n;
    logic w_mosi;
    logic w_rise;
    logic w_fall;
    logic w_ss_fall;
    logic w_ss_rise;

    assign w_sck     = r_sck_sync[c_sync_msb];
    assign w_ss_n    = r_ss_sync[c_sync_msb];
    assign w_mosi    = r_mosi_sync[c_sync_msb];
    assign w_rise    =  w_sck  & ~r_sck_prev;
    assign w_fall    = ~w_sck  &  r_sck_prev;
    assign w_ss_fall = ~w_ss_n &  r_ss_prev;
    assign w_ss_rise =  w_ss_n & ~r_ss_prev;

    // ------------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------------
    state_t       r_state;
    logic [4:0]   r_bit_cnt;    // header bit counter (CMD: 0..7, ADDR: 0..23)
    logic [7:0]   r_cmd_sr;
    logic [23:0]  r_addr;       // current byte address; [1:0] is the byte lane
    logic [31:0]  r_data_buf;
    logic [2:0]   r_bit_idx;    // bit within the current byte, 0 = MSB
    logic         r_rd_valid;   // mem_rdata carries the requested word

    logic [7:0]   w_cmd_next;
    logic [23:0]  w_addr_next;
    logic [23:0]  w_addr_inc;
    logic         w_miso_bit;

    assign w_cmd_next  = {r_cmd_sr[6:0], w_mosi};
    assign w_addr_next = {r_addr[22:0], w_mosi};
    assign w_addr_inc  = r_addr + 24'd1;
    // data_buf[8*lane + 7 - bitidx]
    assign w_miso_bit  = r_data_buf[{r_addr[1:0], ~r_bit_idx}];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_cmd_sr   <= '0;
            r_addr     <= '0;
            r_data_buf <= '0;
            r_bit_idx  <= '0;
            r_rd_valid <= 1'b0;
            spi_miso   <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            busy       <= 1'b0;
        end else begin
            // mem_req is a single-cycle strobe; its data shows up one cycle
            // later, which r_rd_valid tracks.
            mem_req    <= 1'b0;
            r_rd_valid <= mem_req;

            if (w_ss_rise) begin
                // Deselect overrides any SCK edge in the same cycle and drops
                // a read that is still in flight.
                r_state    <= ST_IDLE;
                busy       <= 1'b0;
                spi_miso   <= 1'b0;
                mem_req    <= 1'b0;
                r_rd_valid <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_ss_fall) begin
                            r_state   <= ST_CMD;
                            busy      <= 1'b1;
                            r_bit_cnt <= '0;
                            r_cmd_sr  <= '0;
                            r_addr    <= '0;
                            r_bit_idx <= '0;
                        end
                    end

                    ST_CMD: begin
                        if (w_rise) begin
                            r_cmd_sr <= w_cmd_next;
                            if (r_bit_cnt == 5'd7) begin
                                r_bit_cnt <= '0;
                                r_state   <= (w_cmd_next == READ_CMD) ? ST_ADDR : ST_IGNORE;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end

                    ST_ADDR: begin
                        if (w_rise) begin
                            r_addr <= w_addr_next;
                            if (r_bit_cnt == 5'd23) begin
                                r_bit_cnt <= '0;
                                r_state   <= ST_FETCH;
                                mem_req   <= 1'b1;
                                mem_addr  <= w_addr_next[23:2];
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end

                    ST_FETCH: begin
                        // First word arrives well before the SCK fall that
                        // must present the first data bit.
                        if (r_rd_valid) begin
                            r_data_buf <= mem_rdata;
                            r_bit_idx  <= '0;
                            r_state    <= ST_DATA;
                        end
                    end

                    ST_DATA: begin
                        if (r_rd_valid) begin
                            r_data_buf <= mem_rdata;
                        end
                        if (w_fall) begin
                            spi_miso  <= w_miso_bit;
                            r_bit_idx <= r_bit_idx + 3'd1;
                            if (r_bit_idx == 3'd7) begin
                                // Byte done: advance the address (24-bit wrap).
                                // Leaving lane 3 prefetches the next word so it
                                // is in place before the next fall.
                                r_addr <= w_addr_inc;
                                if (r_addr[1:0] == 2'd3) begin
                                    mem_req  <= 1'b1;
                                    mem_addr <= w_addr_inc[23:2];
                                end
                            end
                        end
                    end

                    ST_IGNORE: begin
                        spi_miso <= 1'b0;
                    end

                    default: begin
                        r_state  <= ST_IDLE;
                        busy     <= 1'b0;
                        spi_miso <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_xip_slave.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module      : tb_spi_flash_xip_slave
// Description : Self-checking bench for spi_flash_xip_slave. A bit-banged
//               SPI master (17 clocks per SCK phase) runs read frames against
//               a flash image model; received bytes and memory requests are
//               compared with values computed directly from the flash image.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_flash_xip_slave;

    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 17;

    logic        clock = 1'b0;
    logic        reset;
    logic        spi_sck;
    logic        spi_ss_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic        mem_req;
    logic [21:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    spi_flash_xip_slave #(
        .SYNC_STAGES (SYNC_STAGES),
        .READ_CMD    (8'h03)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .spi_sck   (spi_sck),
        .spi_ss_n  (spi_ss_n),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // ------------------------------------------------------------------------
    // Flash image: explicit entries override a fixed pseudo-random fill.
    // ------------------------------------------------------------------------
    logic [31:0] mem [int unsigned];

    function automatic logic [31:0] mem_word(input logic [21:0] w);
        int unsigned key;
        key = {10'd0, w};
        if (mem.exists(key)) return mem[key];
        return (key + 32'd1) * 32'h9E3779B1;
    endfunction

    function automatic logic [7:0] exp_byte(input logic [23:0] a);
        logic [31:0] w;
        w = mem_word(a[23:2]);
        return w[{a[1:0], 3'b000} +: 8];
    endfunction

    // Memory port: data valid exactly one cycle after the strobe, noise otherwise.
    logic        rd_pend = 1'b0;
    logic [21:0] rd_addr = '0;
    logic [21:0] req_log [$];
    logic [21:0] exp_reqs [$];
    logic [7:0]  rx_q [$];

    always @(negedge clock) begin
        if (rd_pend) mem_rdata = mem_word(rd_addr);
        else         mem_rdata = $urandom;
        rd_pend = (mem_req === 1'b1);
        rd_addr = mem_addr;
        if (mem_req === 1'b1) req_log.push_back(mem_addr);
    end

    // Activity monitor for the ignored-command frame.
    logic mon_en   = 1'b0;
    int   ign_viol = 0;
    always @(negedge clock) begin
        if (mon_en && (spi_miso !== 1'b0 || mem_req !== 1'b0)) ign_viol++;
    end

    // ------------------------------------------------------------------------
    // SPI master
    // ------------------------------------------------------------------------
    task automatic spi_bit(input logic b, output logic m);
        spi_mosi = b;
        repeat (HALF) @(negedge clock);
        spi_sck = 1'b1;
        m = spi_miso;
        repeat (HALF) @(negedge clock);
        spi_sck = 1'b0;
    endtask

    task automatic frame_start();
        req_log.delete();
        spi_ss_n = 1'b0;
    endtask

    task automatic frame_end();
        repeat (HALF) @(negedge clock);
        spi_ss_n = 1'b1;
        repeat (2 * HALF) @(negedge clock);
    endtask

    task automatic send_header(input logic [7:0] cmd, input logic [23:0] addr);
        logic [31:0] hdr;
        logic m;
        hdr = {cmd, addr};
        for (int i = 31; i >= 0; i--) spi_bit(hdr[i], m);
    endtask

    task automatic run_frame(input logic [7:0] cmd, input logic [23:0] addr, input int nbytes);
        logic       m;
        logic [7:0] b;
        rx_q.delete();
        frame_start();
        send_header(cmd, addr);
        for (int k = 0; k < nbytes; k++) begin
            b = '0;
            for (int j = 0; j < 8; j++) begin
                spi_bit(1'($urandom), m);
                b = {b[6:0], m};
            end
            rx_q.push_back(b);
        end
        frame_end();
    endtask

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    task automatic test_reset();
        reset    = 1'b1;
        spi_sck  = 1'b0;
        spi_ss_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (4) @(negedge clock);
        n_checks++; if (spi_miso !== 1'b0) $display("FAIL reset_miso: got %b, expected 0", spi_miso); else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b, expected 0", mem_req); else n_pass++;
        n_checks++; if (mem_addr !== 22'd0) $display("FAIL reset_mem_addr: got %h, expected 0", mem_addr); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b, expected 0", busy); else n_pass++;
        reset = 1'b0;
        repeat (8) @(negedge clock);
    endtask

    // A fetch happens at the start of the stream and again whenever a streamed
    // byte is the last byte of its word (prefetch of the following word).
    task automatic test_read_frame(input string tag, input logic [23:0] addr, input int nbytes);
        logic [23:0] a;
        exp_reqs.delete();
        exp_reqs.push_back(addr[23:2]);
        for (int k = 0; k < nbytes; k++) begin
            a = addr + 24'(k);
            if (a[1:0] == 2'd3) begin
                a = a + 24'd1;
                exp_reqs.push_back(a[23:2]);
            end
        end
        run_frame(8'h03, addr, nbytes);
        for (int k = 0; k < nbytes; k++) begin
            a = addr + 24'(k);
            n_checks++;
            if (rx_q[k] !== exp_byte(a))
                $display("FAIL %s_byte%0d addr=%h: got %h, expected %h", tag, k, a, rx_q[k], exp_byte(a));
            else n_pass++;
        end
        n_checks++;
        if (req_log.size() != exp_reqs.size())
            $display("FAIL %s_req_count: got %0d, expected %0d", tag, req_log.size(), exp_reqs.size());
        else n_pass++;
        for (int i = 0; i < exp_reqs.size() && i < req_log.size(); i++) begin
            n_checks++;
            if (req_log[i] !== exp_reqs[i])
                $display("FAIL %s_req%0d: got %h, expected %h", tag, i, req_log[i], exp_reqs[i]);
            else n_pass++;
        end
    endtask

    task automatic test_basic();
        mem.delete();
        mem[0] = 32'h44332211;
        test_read_frame("basic", 24'h000000, 4);
        n_checks++;
        if ({rx_q[0], rx_q[1], rx_q[2], rx_q[3]} !== 32'h11223344)
            $display("FAIL basic_rx0: got %h, expected 11223344", {rx_q[0], rx_q[1], rx_q[2], rx_q[3]});
        else n_pass++;
        n_checks++;
        if (req_log.size() == 0 || req_log[0] !== 22'd0)
            $display("FAIL basic_first_req: got %0d entries, expected first addr 0", req_log.size());
        else n_pass++;
    endtask

    task automatic test_cross_word();
        mem.delete();
        mem[0] = 32'h44332211;
        mem[1] = 32'h88776655;
        test_read_frame("cross", 24'h000002, 4);
        n_checks++;
        if ({rx_q[0], rx_q[1], rx_q[2], rx_q[3]} !== 32'h33445566)
            $display("FAIL cross_bytes: got %h, expected 33445566", {rx_q[0], rx_q[1], rx_q[2], rx_q[3]});
        else n_pass++;
    endtask

    task automatic test_wrap();
        mem.delete();
        mem[32'h3FFFFF] = 32'hAA000000;
        mem[0]          = 32'h000000BB;
        test_read_frame("wrap", 24'hFFFFFF, 4);
        n_checks++;
        if (rx_q[0] !== 8'hAA || rx_q[1] !== 8'hBB)
            $display("FAIL wrap_bytes: got %h %h, expected AA BB", rx_q[0], rx_q[1]);
        else n_pass++;
        n_checks++;
        if (req_log.size() < 2 || req_log[1] !== 22'd0)
            $display("FAIL wrap_second_req: got %0d entries, expected second addr 0", req_log.size());
        else n_pass++;
    endtask

    task automatic test_ignore();
        logic [7:0] acc;
        mem.delete();
        ign_viol = 0;
        mon_en   = 1'b1;
        run_frame(8'h0B, 24'h000000, 4);
        mon_en   = 1'b0;
        acc = rx_q[0] | rx_q[1] | rx_q[2] | rx_q[3];
        n_checks++; if (acc !== 8'h00) $display("FAIL ignore_rx: got %h, expected 00", acc); else n_pass++;
        n_checks++; if (req_log.size() != 0) $display("FAIL ignore_req: got %0d, expected 0", req_log.size()); else n_pass++;
        n_checks++; if (ign_viol != 0) $display("FAIL ignore_activity: got %0d cycles, expected 0", ign_viol); else n_pass++;
        test_read_frame("after_ignore", 24'($urandom), 4);
    endtask

    task automatic test_abort();
        logic m;
        logic [31:0] hdr;
        hdr = {8'h03, 24'h123456};
        frame_start();
        for (int i = 31; i >= 12; i--) spi_bit(hdr[i], m);
        n_checks++; if (busy !== 1'b1) $display("FAIL abort_busy_before: got %b, expected 1", busy); else n_pass++;
        spi_ss_n = 1'b1;
        repeat (SYNC_STAGES + 2) @(posedge clock);
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy_after: got %b, expected 0", busy); else n_pass++;
        n_checks++; if (spi_miso !== 1'b0) $display("FAIL abort_miso: got %b, expected 0", spi_miso); else n_pass++;
        repeat (2 * HALF) @(negedge clock);
        n_checks++; if (req_log.size() != 0) $display("FAIL abort_req: got %0d, expected 0", req_log.size()); else n_pass++;
        test_read_frame("after_abort", 24'h123456, 4);
    endtask

    task automatic test_reset_mid();
        logic m;
        mem.delete();
        mem[32'h40] = 32'hFFFFFFFF;
        frame_start();
        send_header(8'h03, 24'h000100);
        for (int j = 0; j < 4; j++) spi_bit(1'b0, m);
        repeat (6) @(negedge clock);
        n_checks++; if (spi_miso !== 1'b1) $display("FAIL midreset_miso_before: got %b, expected 1", spi_miso); else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++; if (spi_miso !== 1'b0) $display("FAIL midreset_miso: got %b, expected 0", spi_miso); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %b, expected 0", busy); else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL midreset_mem_req: got %b, expected 0", mem_req); else n_pass++;
        spi_ss_n = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2 * HALF) @(negedge clock);
        test_read_frame("after_reset", 24'h000101, 4);
    endtask

    task automatic test_random();
        logic [23:0] addr;
        int          nbytes;
        mem.delete();
        for (int f = 0; f < 8; f++) begin
            if ($urandom_range(0, 2) == 0) addr = 24'hFFFFF8 + 24'($urandom_range(0, 7));
            else                           addr = 24'($urandom);
            nbytes = $urandom_range(1, 6);
            mem[{10'd0, addr[23:2]}] = $urandom;
            test_read_frame($sformatf("rand%0d", f), addr, nbytes);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cross_word();
        test_wrap();
        test_ignore();
        test_abort();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
